pga_alarm_ctrl: RTL and testbench

Parametrised successor to the single-threshold PGA alarm. It monitors NCH signed acceleration channels and raises a peak-ground-acceleration alarm only after TRIG_COUNT consecutive valid samples exceed the threshold on any channel. Once raised, the alarm is held until CLEAR_COUNT consecutive quiet samples have passed; in latched mode it also waits for an operator accept. It sits between the scaling stage and the alarm/annunciator logic, and additionally reports the triggering channels and the peak magnitude.

---
 rtl/pga_alarm_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pga_alarm_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pga_alarm_ctrl.sv
// Peak-ground-acceleration alarm controller.
// Watches NCH signed acceleration channels. The alarm is raised after
// TRIG_COUNT consecutive exceeding samples and released after CLEAR_COUNT
// consecutive quiet samples (plus an operator accept when LATCH=1).
// It also reports which channels exceeded and the peak magnitude of the event.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no event; counters, flags and peak are clear
// ARM    | counting consecutive exceeding samples towards the trigger
// ALARM  | alarm raised; counting consecutive quiet samples
// HOLD   | quiet period done; alarm held until operator accept
module pga_alarm_ctrl #(
    parameter int               NCH           = 3,
    parameter int               DW            = 24,
    parameter logic [DW-1:0]    PGA_THRESHOLD = 24'h100000,
    parameter int               TRIG_COUNT    = 4,
    parameter int               CLEAR_COUNT   = 16,
    parameter int               LATCH         = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [NCH*DW-1:0]   i_data,
    input  logic                i_accept,
    output logic                o_alarm,
    output logic [NCH-1:0]      o_alarm_ch,
    output logic [DW-1:0]       o_peak,
    output logic [1:0]          o_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARM   = 2'd1;
    localparam logic [1:0] ALARM = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int TW = $clog2(TRIG_COUNT + 1);
    localparam int QW = $clog2(CLEAR_COUNT + 1);
    localparam logic [TW-1:0] TRIG_MAX  = TW'(TRIG_COUNT);
    localparam logic [QW-1:0] CLEAR_MAX = QW'(CLEAR_COUNT);

    logic [1:0]     state, state_n;
    logic [TW-1:0]  trig_cnt, trig_n, trig_inc;
    logic [QW-1:0]  quiet_cnt, quiet_n, quiet_inc;
    logic           alarm_n;
    logic [NCH-1:0] ch_n;
    logic [DW-1:0]  peak_n;

    logic [DW-1:0]  mag [NCH];
    logic [NCH-1:0] exceed;
    logic           any_exceed;
    logic [DW-1:0]  sample_max;
    logic [NCH-1:0] ch_upd;
    logic [DW-1:0]  peak_upd;
    logic           go_idle;

    // Per-channel magnitude; the most negative input maps onto 2^(DW-1) naturally.
    always_comb begin
        sample_max = '0;
        exceed     = '0;
        for (int c = 0; c < NCH; c++) begin
            if (i_data[c*DW + DW - 1])
                mag[c] = (~i_data[c*DW +: DW]) + 1'b1;
            else
                mag[c] = i_data[c*DW +: DW];
            exceed[c] = (mag[c] > PGA_THRESHOLD);
            if (mag[c] > sample_max)
                sample_max = mag[c];
        end
    end

    assign any_exceed = |exceed;
    assign ch_upd     = o_alarm_ch | exceed;
    assign peak_upd   = (sample_max > o_peak) ? sample_max : o_peak;
    assign trig_inc   = (trig_cnt == TRIG_MAX) ? trig_cnt : trig_cnt + 1'b1;
    assign quiet_inc  = (quiet_cnt == CLEAR_MAX) ? quiet_cnt : quiet_cnt + 1'b1;

    // Next-state, counter and event-record logic.
    always_comb begin
        state_n = state;
        trig_n  = trig_cnt;
        quiet_n = quiet_cnt;
        alarm_n = o_alarm;
        ch_n    = o_alarm_ch;
        peak_n  = o_peak;
        go_idle = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && any_exceed) begin
                    ch_n    = exceed;
                    peak_n  = sample_max;
                    quiet_n = '0;
                    if (TRIG_COUNT == 1) begin
                        state_n = ALARM;
                        alarm_n = 1'b1;
                        trig_n  = TRIG_MAX;
                    end else begin
                        state_n = ARM;
                        trig_n  = TW'(1);
                    end
                end
            end
            ARM: begin
                if (i_valid) begin
                    if (any_exceed) begin
                        ch_n   = ch_upd;
                        peak_n = peak_upd;
                        trig_n = trig_inc;
                        if (trig_inc == TRIG_MAX) begin
                            state_n = ALARM;
                            alarm_n = 1'b1;
                            quiet_n = '0;
                        end
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            ALARM: begin
                if (i_valid) begin
                    ch_n   = ch_upd;
                    peak_n = peak_upd;
                    if (any_exceed) begin
                        quiet_n = '0;
                    end else begin
                        quiet_n = quiet_inc;
                        if (quiet_inc == CLEAR_MAX) begin
                            if (LATCH != 0)
                                state_n = HOLD;
                            else
                                go_idle = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // HOLD: a fresh exceed outranks a simultaneous accept.
                if (i_valid && any_exceed) begin
                    state_n = ALARM;
                    quiet_n = '0;
                    ch_n    = ch_upd;
                    peak_n  = peak_upd;
                end else if (i_accept) begin
                    go_idle = 1'b1;
                end else if (i_valid) begin
                    ch_n   = ch_upd;
                    peak_n = peak_upd;
                end
            end
        endcase
        if (go_idle) begin
            state_n = IDLE;
            trig_n  = '0;
            quiet_n = '0;
            alarm_n = 1'b0;
            ch_n    = '0;
            peak_n  = '0;
        end
    end

    // Register all state and outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            trig_cnt   <= '0;
            quiet_cnt  <= '0;
            o_alarm    <= 1'b0;
            o_alarm_ch <= '0;
            o_peak     <= '0;
        end else begin
            state      <= state_n;
            trig_cnt   <= trig_n;
            quiet_cnt  <= quiet_n;
            o_alarm    <= alarm_n;
            o_alarm_ch <= ch_n;
            o_peak     <= peak_n;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pga_alarm_ctrl.sv
// Directed bench for pga_alarm_ctrl: default instance plus a non-latched,
// single-trigger, short-clear instance.
module tb_pga_alarm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, accept;
    logic [71:0] data;
    logic        alarm;
    logic [2:0]  alarm_ch;
    logic [23:0] peak;
    logic [1:0]  state;

    logic        valid2, accept2;
    logic [71:0] data2;
    logic        alarm2;
    logic [2:0]  alarm_ch2;
    logic [23:0] peak2;
    logic [1:0]  state2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pga_alarm_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
        .i_accept(accept), .o_alarm(alarm), .o_alarm_ch(alarm_ch),
        .o_peak(peak), .o_state(state)
    );

    pga_alarm_ctrl #(.LATCH(0), .TRIG_COUNT(1), .CLEAR_COUNT(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .i_data(data2),
        .i_accept(accept2), .o_alarm(alarm2), .o_alarm_ch(alarm_ch2),
        .o_peak(peak2), .o_state(state2)
    );

    // Apply one cycle of stimulus on the default instance; outputs are
    // observable on return (1 ns after the rising edge).
    task automatic send(input logic v, input logic [23:0] z, input logic [23:0] y,
                        input logic [23:0] x, input logic acc);
        @(negedge clk);
        valid  = v;
        data   = {z, y, x};
        accept = acc;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        accept = 1'b0;
    endtask

    task automatic send2(input logic v, input logic [23:0] x);
        @(negedge clk);
        valid2 = v;
        data2  = {48'd0, x};
        @(posedge clk);
        #1;
        valid2 = 1'b0;
    endtask

    task automatic test_reset;
        send(1'b1, 24'($urandom), 24'($urandom), 24'h300000, 1'b0);
        checks++;
        if (state !== 2'd1) begin
            failures++; $display("FAIL rst_pre_state got=%0d exp=1", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (alarm !== 1'b0 || alarm_ch !== 3'b000 || peak !== 24'h0 || state !== 2'd0) begin
            failures++;
            $display("FAIL rst_async got alarm=%0b ch=%b peak=%h state=%0d exp all 0",
                     alarm, alarm_ch, peak, state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0 || peak !== 24'h0) begin
            failures++; $display("FAIL rst_release got state=%0d peak=%h exp 0/0", state, peak);
        end
    endtask

    task automatic test_arm_abort;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 24'h0, 24'h0, 24'h100001, 1'b0);
            checks++;
            if (state !== 2'd1 || alarm !== 1'b0) begin
                failures++;
                $display("FAIL arm_%0d got state=%0d alarm=%0b exp 1/0", i, state, alarm);
            end
        end
        checks++;
        if (peak !== 24'h100001 || alarm_ch !== 3'b001) begin
            failures++; $display("FAIL arm_peak got peak=%h ch=%b exp 100001/001", peak, alarm_ch);
        end
        send(1'b1, 24'h0, 24'h0, 24'h000010, 1'b0);
        checks++;
        if (state !== 2'd0 || alarm !== 1'b0 || peak !== 24'h0 || alarm_ch !== 3'b000) begin
            failures++;
            $display("FAIL arm_abort got state=%0d alarm=%0b peak=%h ch=%b exp 0/0/0/000",
                     state, alarm, peak, alarm_ch);
        end
        send(1'b1, 24'h0, 24'h0, 24'h100000, 1'b0);
        checks++;
        if (state !== 2'd0 || peak !== 24'h0) begin
            failures++; $display("FAIL equal_thr got state=%0d peak=%h exp 0/0", state, peak);
        end
    endtask

    task automatic test_trigger_gaps;
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 24'h0, 24'hE80000, 24'h0, 1'b0);
            if (i < 4) begin
                checks++;
                if (state !== 2'd1 || alarm !== 1'b0) begin
                    failures++;
                    $display("FAIL trig_%0d got state=%0d alarm=%0b exp 1/0", i, state, alarm);
                end
                send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0);
                checks++;
                if (state !== 2'd1) begin
                    failures++; $display("FAIL gap_%0d got state=%0d exp 1", i, state);
                end
            end
        end
        checks++;
        if (alarm !== 1'b1 || state !== 2'd2 || alarm_ch !== 3'b010 || peak !== 24'h180000) begin
            failures++;
            $display("FAIL trig_fire got alarm=%0b state=%0d ch=%b peak=%h exp 1/2/010/180000",
                     alarm, state, alarm_ch, peak);
        end
    endtask

    task automatic test_most_negative;
        send(1'b1, 24'h800000, 24'h0, 24'h0, 1'b0);
        checks++;
        if (peak !== 24'h800000 || alarm_ch !== 3'b110 || state !== 2'd2) begin
            failures++;
            $display("FAIL most_neg got peak=%h ch=%b state=%0d exp 800000/110/2",
                     peak, alarm_ch, state);
        end
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b1);
        checks++;
        if (state !== 2'd2 || alarm !== 1'b1) begin
            failures++; $display("FAIL accept_in_alarm got state=%0d alarm=%0b exp 2/1", state, alarm);
        end
    endtask

    task automatic test_hold_accept;
        for (int i = 1; i <= 16; i++) begin
            send(1'b1, 24'h0, 24'h0, 24'h0, 1'b0);
            if (i == 15) begin
                checks++;
                if (state !== 2'd2) begin
                    failures++; $display("FAIL quiet_15 got state=%0d exp 2", state);
                end
            end
        end
        checks++;
        if (state !== 2'd3 || alarm !== 1'b1) begin
            failures++; $display("FAIL hold_entry got state=%0d alarm=%0b exp 3/1", state, alarm);
        end
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b0);
        checks++;
        if (state !== 2'd3) begin
            failures++; $display("FAIL hold_idle_cycle got state=%0d exp 3", state);
        end
        send(1'b1, 24'h0, 24'h0, 24'h200000, 1'b1);
        checks++;
        if (state !== 2'd2 || alarm !== 1'b1 || alarm_ch !== 3'b111 || peak !== 24'h800000) begin
            failures++;
            $display("FAIL exceed_beats_accept got state=%0d alarm=%0b ch=%b peak=%h exp 2/1/111/800000",
                     state, alarm, alarm_ch, peak);
        end
        for (int i = 0; i < 16; i++)
            send(1'b1, 24'h0, 24'h0, 24'h0, 1'b0);
        checks++;
        if (state !== 2'd3) begin
            failures++; $display("FAIL hold_again got state=%0d exp 3", state);
        end
        send(1'b0, 24'h0, 24'h0, 24'h0, 1'b1);
        checks++;
        if (state !== 2'd0 || alarm !== 1'b0 || alarm_ch !== 3'b000 || peak !== 24'h0) begin
            failures++;
            $display("FAIL accept_release got state=%0d alarm=%0b ch=%b peak=%h exp 0/0/000/0",
                     state, alarm, alarm_ch, peak);
        end
    endtask

    task automatic test_autoclear;
        send2(1'b1, 24'h100001);
        checks++;
        if (alarm2 !== 1'b1 || state2 !== 2'd2 || alarm_ch2 !== 3'b001) begin
            failures++;
            $display("FAIL auto_fire got alarm=%0b state=%0d ch=%b exp 1/2/001", alarm2, state2, alarm_ch2);
        end
        send2(1'b1, 24'h0);
        checks++;
        if (alarm2 !== 1'b1 || state2 !== 2'd2) begin
            failures++; $display("FAIL auto_quiet1 got alarm=%0b state=%0d exp 1/2", alarm2, state2);
        end
        send2(1'b1, 24'h0);
        checks++;
        if (alarm2 !== 1'b0 || state2 !== 2'd0 || peak2 !== 24'h0 || alarm_ch2 !== 3'b000) begin
            failures++;
            $display("FAIL auto_clear got alarm=%0b state=%0d peak=%h ch=%b exp 0/0/0/000",
                     alarm2, state2, peak2, alarm_ch2);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid   = 1'b0;
        accept  = 1'b0;
        data    = '0;
        valid2  = 1'b0;
        accept2 = 1'b0;
        data2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_arm_abort();
        test_trigger_gaps();
        test_most_negative();
        test_hold_accept();
        test_autoclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
